seq_divider: RTL and testbench

Multi-cycle integer divider implementing the RISC-V M-extension DIV/DIVU/REM/REMU semantics. It is the responder side of the execute stage's divide handshake: execute drives operands, `start` and `signed_div`, and holds its pipeline stalled until `finished` pulses. It then captures `quotient` or `remainder` into the EX/MEM register. The core is a radix-2 restoring divider that produces one quotient bit per cycle.

---
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             status,
    output logic             finished
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    // One extra headroom bit so the trial subtraction's sign bit is explicit.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             qbit;
    logic [WIDTH:0]   prem_next;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             div_zero;
    logic             overflow;

    assign shifted   = {prem_q, dvd_q[WIDTH-1]};
    assign trial     = shifted - {2'b00, dvs_q};
    assign qbit      = ~trial[WIDTH+1];
    assign prem_next = qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
    assign quo_mag   = {dvd_q[WIDTH-2:0], qbit};
    assign quo_fix   = (sgn_q && (dvd_neg_q ^ dvs_neg_q)) ? -quo_mag : quo_mag;
    assign rem_fix   = (sgn_q && dvd_neg_q) ? -prem_next[WIDTH-1:0] : prem_next[WIDTH-1:0];

    assign div_zero  = (divisor == '0);
    assign overflow  = signed_div && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_d     = signed_div;
                    dvd_neg_d = dividend[WIDTH-1];
                    dvs_neg_d = divisor[WIDTH-1];
                    dvd_d     = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
                    dvs_d     = (signed_div && divisor[WIDTH-1]) ? -divisor : divisor;
                    prem_d    = '0;
                    if (div_zero) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else if (overflow) begin
                        quo_d   = dividend;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prem_d = prem_next;
                dvd_d  = quo_mag;
                cnt_d  = cnt_q - CW'(1);
                // Last iteration: results go straight to the output registers.
                if (cnt_q == CW'(1)) begin
                    quo_d   = quo_fix;
                    rem_d   = rem_fix;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            prem_q    <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            prem_q    <= prem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign status    = (state_q == CALC);
    assign finished  = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        status;
    logic        finished;

    int tests = 0;
    int fails = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_div (sd),
        .dividend   (a),
        .divisor    (b),
        .quotient   (quotient),
        .remainder  (remainder),
        .status     (status),
        .finished   (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V division rules with plain integer arithmetic.
    task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        int sx;
        int sy;
        sx = x;
        sy = y;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF; r = x; lat = 1;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x; r = 32'd0; lat = 1;
        end else if (s) begin
            q = sx / sy; r = sx % sy; lat = 33;
        end else begin
            q = x / y; r = x % y; lat = 33;
        end
    endtask

    task automatic do_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                         input string tag, output logic [31:0] q_o, output logic [31:0] r_o);
        logic [31:0] eq;
        logic [31:0] er;
        int lat;
        int bad;
        model(s, x, y, eq, er, lat);
        @(negedge clk);
        sd = s; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sd = ~s;
        bad = 0;
        q_o = '0;
        r_o = '0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (status !== (c < lat)) bad++;
            if (finished !== (c == lat)) bad++;
            if (c == lat) begin
                q_o = quotient;
                r_o = remainder;
            end
        end
        check({tag, " timing"}, 32'(bad), 32'd0);
        check({tag, " quotient"}, q_o, eq);
        check({tag, " remainder"}, r_o, er);
        check({tag, " hold"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] q1;
        logic [31:0] r1;
        logic [31:0] q2;
        logic [31:0] r2;
        int bad;
        int nfin;

        reset = 1'b0; start = 1'b0; sd = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset status", 32'(status), 32'd0);
        check("reset finished", 32'(finished), 32'd0);
        reset = 1'b1;

        do_op(1'b0, 32'd100, 32'd7, "udiv 100/7", q, r);
        check("udiv 100/7 const q", q, 32'd14);
        check("udiv 100/7 const r", r, 32'd2);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "sdiv -7/2", q, r);
        check("sdiv -7/2 const q", q, 32'hFFFF_FFFD);
        check("sdiv -7/2 const r", r, 32'hFFFF_FFFF);
        do_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, "sdiv -7/-2", q, r);
        check("sdiv -7/-2 const q", q, 32'd3);
        check("sdiv -7/-2 const r", r, 32'hFFFF_FFFF);
        do_op(1'b0, 32'h1234, 32'd0, "udiv by zero", q, r);
        check("udiv0 const q", q, 32'hFFFF_FFFF);
        check("udiv0 const r", r, 32'h1234);
        do_op(1'b1, 32'h1234, 32'd0, "sdiv by zero", q, r);
        check("sdiv0 const q", q, 32'hFFFF_FFFF);
        check("sdiv0 const r", r, 32'h1234);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "signed overflow", q, r);
        check("ovf const q", q, 32'h8000_0000);
        check("ovf const r", r, 32'd0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "unsigned ovf operands", q, r);
        check("uovf const q", q, 32'd0);
        check("uovf const r", r, 32'h8000_0000);

        // start held high across DONE; operands changed mid-operation
        @(negedge clk);
        sd = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        bad = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int c = 1; c <= 68; c++) begin
            @(negedge clk);
            if (c == 10) begin a = 32'd1000; b = 32'd9; end
            if (status !== ((c >= 1 && c <= 32) || (c >= 35 && c <= 66))) bad++;
            if (finished !== (c == 33 || c == 67)) bad++;
            if (c == 33) begin q1 = quotient; r1 = remainder; end
            if (c == 67) begin q2 = quotient; r2 = remainder; start = 1'b0; end
        end
        check("b2b timing", 32'(bad), 32'd0);
        check("b2b first q", q1, 32'd14);
        check("b2b first r", r1, 32'd2);
        check("b2b second q", q2, 32'd111);
        check("b2b second r", r2, 32'd1);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        sd = 1'b0; a = 32'h0000_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset status", 32'(status), 32'd0);
        check("midreset finished", 32'(finished), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nfin = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (finished) nfin++;
        end
        check("midreset no finish", 32'(nfin), 32'd0);
        do_op(1'b0, 32'd20, 32'd3, "post-reset 20/3", q, r);
        check("post-reset const q", q, 32'd6);
        check("post-reset const r", r, 32'd2);

        for (int i = 0; i < 24; i++) begin
            logic        rs;
            logic [31:0] ra;
            logic [31:0] rb;
            int          sel;
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = $urandom_range(0, 300); rb = $urandom_range(1, 20); end
            else if (sel == 3) rb = $urandom_range(1, 255);
            do_op(rs, ra, rb, $sformatf("rand%0d", i), q, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
